// File: rtl/sync_glitch_filter_pkg.sv
// Shared helpers for the multi-channel synchronising glitch filter.
package sync_glitch_filter_pkg;

  function automatic int unsigned filt_cnt_width(input int unsigned filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

  // All-ones value for a counter of width w (w < 64).
  function automatic longint unsigned glitch_sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_glitch_filter_bit.sv
// One channel: synchroniser chain, stability qualifier, level and edge outputs.
module sync_glitch_filter_bit
  import sync_glitch_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  input  logic i_bypass,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_abort
);

  localparam int unsigned CNT_W = filt_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  logic                   abort;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    abort  = 1'b0;
    if (i_bypass) begin
      cnt_d = '0;
      if (s != q_q) begin
        q_d    = s;
        rise_d = s;
        fall_d = ~s;
      end
    end else if (s == q_q) begin
      cnt_d = '0;
      abort = (cnt_q != '0);
    end else if (cnt_q == CNT_LAST) begin
      q_d    = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_q     = q_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  // Consumed by the same edge's glitch-counter update, never leaves the block.
  assign o_abort = abort;

endmodule

// File: rtl/sync_glitch_filter_n_ch.sv
// WIDTH independent filtered channels plus a shared saturating glitch counter.
module sync_glitch_filter_n_ch
  import sync_glitch_filter_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned GLITCH_CNT_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [WIDTH-1:0]        i_d,
  input  logic                    i_bypass,
  input  logic                    i_glitch_clr,
  output logic [WIDTH-1:0]        o_q,
  output logic [WIDTH-1:0]        o_rise,
  output logic [WIDTH-1:0]        o_fall,
  output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
);

  localparam logic [GLITCH_CNT_W-1:0] GCNT_MAX =
    GLITCH_CNT_W'(glitch_sat_max(GLITCH_CNT_W));

  logic [WIDTH-1:0]        abort;
  logic [GLITCH_CNT_W-1:0] gcnt_q, gcnt_d;

  for (genvar b = 0; b < WIDTH; b++) begin : g_ch
    sync_glitch_filter_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_bit (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_d[b]),
      .i_bypass(i_bypass),
      .o_q     (o_q[b]),
      .o_rise  (o_rise[b]),
      .o_fall  (o_fall[b]),
      .o_abort (abort[b])
    );
  end

  always_comb begin
    gcnt_d = gcnt_q;
    if (i_glitch_clr) begin
      gcnt_d = '0;
    end else if ((|abort) && (gcnt_q != GCNT_MAX)) begin
      gcnt_d = gcnt_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign o_glitch_cnt = gcnt_q;

endmodule
